alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 A  input  8  operand A.
REQ-004 B  input  8  operand B.
REQ-005 data_in  input  8  external data bus (load source).
REQ-006 op_dec  input  5  decoded opcode.
REQ-007 ans_ex  input  8  previous registered result (accumulator/forwarding operand).
REQ-008 ans_tmp  output  8  combinational result of current op.
REQ-009 flag_ex  output  4  registered flags: [3]=V overflow, [2]=N sign, [1]=Z zero, [0]=C carry/borrow.
REQ-010 data_out_buff  output  8  registered store buffer.

Function
REQ-011 ans_tmp SHALL be combinational from A, B, data_in, ans_ex, op_dec and flag_ex[0]; 0-cycle latency.
REQ-012 flag_ex and data_out_buff SHALL update only on rising clk edge; flags reflect the op present before that edge (1-cycle latency).
REQ-013 Opcodes 00000-00111: ADD A+B; ADC A+B+C; SUB A-B; SBB A-B-C; AND; OR; XOR; NOT A.
REQ-014 Opcodes 01000-01111: INC A; DEC A; NEG A (two's complement); PASS B; SHL A (logical, 0 in); SHR A (logical, 0 in); ASR A (sign kept); ROL A.
REQ-015 Opcodes 10000-10111: ROR A; RCL A through C; RCR A through C; CMP (ans_tmp=A, flags as SUB); NOR; XNOR; PASS A; PASS ans_ex.
REQ-016 Opcodes 11000-11111: LOAD (ans_tmp=data_in); STORE (ans_tmp=A, data_out_buff<=A); MUL (low byte of A*B); SWAP nibbles of A; CLC (C<=0, ans_tmp=A); STC (C<=1, ans_tmp=A); ACC (ans_ex+A); NOP (ans_tmp=ans_ex).
REQ-017 Arithmetic ops (ADD, ADC, SUB, SBB, INC, DEC, NEG, CMP, ACC) SHALL update all four flags; C = carry out of bit 7 for add-type, borrow (unsigned A<subtrahend) for subtract-type; V = signed two's-complement overflow.
REQ-018 Logic ops and PASS/LOAD/SWAP SHALL update Z and N from ans_tmp, clear V, hold C.
REQ-019 Shifts/rotates SHALL set C to the bit shifted out, update Z and N, clear V.
REQ-020 MUL SHALL set C=V=1 when the 16-bit product high byte is nonzero, else 0; Z, N from low byte.
REQ-021 CLC/STC SHALL change only C; STORE and NOP SHALL leave all flags unchanged.
REQ-022 Z SHALL be 1 exactly when the 8-bit ans_tmp is 0x00 (e.g. 0xFF+0x01 -> Z=1, C=1).
REQ-023 data_out_buff SHALL change only on STORE; all other ops hold it.
REQ-024 Unlisted codes do not exist (all 32 decoded); inputs X-free assumed not required — outputs defined for every code.

Reset
REQ-025 While reset is high at a rising edge, flag_ex<=4'b0000 and data_out_buff<=8'h00; reset has priority over any op including STORE.
REQ-026 While reset is high, ans_tmp SHALL be driven 8'h00 combinationally.
REQ-027 Reset asserted mid-sequence SHALL discard the pending flag/store update of that cycle; ADC after reset uses C=0.

Configuration
REQ-028 Macro ALU_MUL_EN: defined -> opcode 11010 is MUL per REQ-020 (8x8 multiplier instantiated).
REQ-029 ALU_MUL_EN undefined -> opcode 11010 SHALL give ans_tmp=A and leave all flags unchanged; no multiplier logic present.

Verification
REQ-030 A=64, B=192, op=00000 -> ans_tmp=0x00; after edge flag_ex=0011 (Z=1, C=1).
REQ-031 A=64, B=192, op=00010 -> ans_tmp=0x80; after edge flag_ex=1101 (V=1, N=1, C=1).
REQ-032 A=64, B=192, op=00100 -> ans_tmp=0x40, flag_ex=0000 (C held 0 from reset); then op=00001 with C=1 preloaded via STC -> ans_tmp=0x01.
REQ-033 A=192, B=1, op=11001 -> data_out_buff=0xC0 after edge, flags unchanged; op=11011 -> ans_tmp=0x0C.
REQ-034 A=192, B=1, op=11010 with ALU_MUL_EN -> ans_tmp=0xC0, flag_ex=0100; without macro -> ans_tmp=0xC0, flags unchanged.
REQ-035 Assert reset during STORE of A=0x55 -> data_out_buff=0x00, flag_ex=0000, ans_tmp=0x00 while reset high.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: 8-bit single-cycle ALU with combinational result, registered flags and store buffer.
// Build option ALU_MUL_EN: when defined, opcode 11010 is an 8x8 multiply; otherwise it passes A.
module alu_exec (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [7:0] data_in,
    input  logic [4:0] op_dec,
    input  logic [7:0] ans_ex,
    output logic [7:0] ans_tmp,
    output logic [3:0] flag_ex,
    output logic [7:0] data_out_buff
);
    localparam int unsigned W   = 8;
    localparam int unsigned OPW = 5;
    localparam int unsigned FW  = 4;

    localparam logic [OPW-1:0] OP_ADD   = 5'b00000;
    localparam logic [OPW-1:0] OP_ADC   = 5'b00001;
    localparam logic [OPW-1:0] OP_SUB   = 5'b00010;
    localparam logic [OPW-1:0] OP_SBB   = 5'b00011;
    localparam logic [OPW-1:0] OP_AND   = 5'b00100;
    localparam logic [OPW-1:0] OP_OR    = 5'b00101;
    localparam logic [OPW-1:0] OP_XOR   = 5'b00110;
    localparam logic [OPW-1:0] OP_NOT   = 5'b00111;
    localparam logic [OPW-1:0] OP_INC   = 5'b01000;
    localparam logic [OPW-1:0] OP_DEC   = 5'b01001;
    localparam logic [OPW-1:0] OP_NEG   = 5'b01010;
    localparam logic [OPW-1:0] OP_PASSB = 5'b01011;
    localparam logic [OPW-1:0] OP_SHL   = 5'b01100;
    localparam logic [OPW-1:0] OP_SHR   = 5'b01101;
    localparam logic [OPW-1:0] OP_ASR   = 5'b01110;
    localparam logic [OPW-1:0] OP_ROL   = 5'b01111;
    localparam logic [OPW-1:0] OP_ROR   = 5'b10000;
    localparam logic [OPW-1:0] OP_RCL   = 5'b10001;
    localparam logic [OPW-1:0] OP_RCR   = 5'b10010;
    localparam logic [OPW-1:0] OP_CMP   = 5'b10011;
    localparam logic [OPW-1:0] OP_NOR   = 5'b10100;
    localparam logic [OPW-1:0] OP_XNOR  = 5'b10101;
    localparam logic [OPW-1:0] OP_PASSA = 5'b10110;
    localparam logic [OPW-1:0] OP_PASSX = 5'b10111;
    localparam logic [OPW-1:0] OP_LOAD  = 5'b11000;
    localparam logic [OPW-1:0] OP_STORE = 5'b11001;
    localparam logic [OPW-1:0] OP_MUL   = 5'b11010;
    localparam logic [OPW-1:0] OP_SWAP  = 5'b11011;
    localparam logic [OPW-1:0] OP_CLC   = 5'b11100;
    localparam logic [OPW-1:0] OP_STC   = 5'b11101;
    localparam logic [OPW-1:0] OP_ACC   = 5'b11110;
    localparam logic [OPW-1:0] OP_NOP   = 5'b11111;

    // How the current op affects the flag register
    typedef enum logic [2:0] {
        FL_NONE,
        FL_ARITH,
        FL_LOGIC,
        FL_SHIFT,
        FL_CARRY,
        FL_MUL
    } flag_cls_e;

    flag_cls_e      cls;
    logic [W-1:0]   res_pre;
    logic [W-1:0]   ans_res;
    logic [W-1:0]   ar_x;
    logic [W-1:0]   ar_y;
    logic           ar_cin;
    logic           ar_sub;
    logic [W:0]     ar_wide;
    logic [W-1:0]   ar_res;
    logic           ar_c;
    logic           ar_v;
    logic           sh_c;
    logic           c_set;
    logic           store_en;
    logic           c_cur;
    logic [FW-1:0]  flag_nxt;

    assign c_cur = flag_ex[0];

`ifdef ALU_MUL_EN
    localparam int unsigned PW = 2 * W;
    logic [PW-1:0] prod;
    logic          mul_hi;

    assign prod   = PW'(A) * PW'(B);
    assign mul_hi = (prod[PW-1:W] != '0);
`endif

    // Opcode decode: non-arithmetic result, adder operands and flag class
    always_comb begin
        res_pre  = A;
        ar_x     = '0;
        ar_y     = '0;
        ar_cin   = 1'b0;
        ar_sub   = 1'b0;
        sh_c     = c_cur;
        c_set    = c_cur;
        store_en = 1'b0;
        cls      = FL_NONE;
        case (op_dec)
            OP_ADD:   begin ar_x = A; ar_y = B; cls = FL_ARITH; end
            OP_ADC:   begin ar_x = A; ar_y = B; ar_cin = c_cur; cls = FL_ARITH; end
            OP_SUB:   begin ar_x = A; ar_y = B; ar_sub = 1'b1; cls = FL_ARITH; end
            OP_SBB:   begin ar_x = A; ar_y = B; ar_cin = c_cur; ar_sub = 1'b1; cls = FL_ARITH; end
            OP_AND:   begin res_pre = A & B; cls = FL_LOGIC; end
            OP_OR:    begin res_pre = A | B; cls = FL_LOGIC; end
            OP_XOR:   begin res_pre = A ^ B; cls = FL_LOGIC; end
            OP_NOT:   begin res_pre = ~A; cls = FL_LOGIC; end
            OP_INC:   begin ar_x = A; ar_y = W'(1); cls = FL_ARITH; end
            OP_DEC:   begin ar_x = A; ar_y = W'(1); ar_sub = 1'b1; cls = FL_ARITH; end
            OP_NEG:   begin ar_x = '0; ar_y = A; ar_sub = 1'b1; cls = FL_ARITH; end
            OP_PASSB: begin res_pre = B; cls = FL_LOGIC; end
            OP_SHL:   begin res_pre = {A[W-2:0], 1'b0}; sh_c = A[W-1]; cls = FL_SHIFT; end
            OP_SHR:   begin res_pre = {1'b0, A[W-1:1]}; sh_c = A[0]; cls = FL_SHIFT; end
            OP_ASR:   begin res_pre = {A[W-1], A[W-1:1]}; sh_c = A[0]; cls = FL_SHIFT; end
            OP_ROL:   begin res_pre = {A[W-2:0], A[W-1]}; sh_c = A[W-1]; cls = FL_SHIFT; end
            OP_ROR:   begin res_pre = {A[0], A[W-1:1]}; sh_c = A[0]; cls = FL_SHIFT; end
            OP_RCL:   begin res_pre = {A[W-2:0], c_cur}; sh_c = A[W-1]; cls = FL_SHIFT; end
            OP_RCR:   begin res_pre = {c_cur, A[W-1:1]}; sh_c = A[0]; cls = FL_SHIFT; end
            OP_CMP:   begin ar_x = A; ar_y = B; ar_sub = 1'b1; cls = FL_ARITH; end
            OP_NOR:   begin res_pre = ~(A | B); cls = FL_LOGIC; end
            OP_XNOR:  begin res_pre = ~(A ^ B); cls = FL_LOGIC; end
            OP_PASSA: begin res_pre = A; cls = FL_LOGIC; end
            OP_PASSX: begin res_pre = ans_ex; cls = FL_LOGIC; end
            OP_LOAD:  begin res_pre = data_in; cls = FL_LOGIC; end
            OP_STORE: begin res_pre = A; store_en = 1'b1; end
`ifdef ALU_MUL_EN
            OP_MUL:   begin res_pre = prod[W-1:0]; cls = FL_MUL; end
`else
            OP_MUL:   begin res_pre = A; end
`endif
            OP_SWAP:  begin res_pre = {A[W/2-1:0], A[W-1:W/2]}; cls = FL_LOGIC; end
            OP_CLC:   begin res_pre = A; c_set = 1'b0; cls = FL_CARRY; end
            OP_STC:   begin res_pre = A; c_set = 1'b1; cls = FL_CARRY; end
            OP_ACC:   begin ar_x = ans_ex; ar_y = A; cls = FL_ARITH; end
            OP_NOP:   begin res_pre = ans_ex; end
            default:  begin res_pre = A; end
        endcase
    end

    // Shared 9-bit adder/subtractor; bit 8 is carry for add and borrow for subtract
    always_comb begin
        if (ar_sub) begin
            ar_wide = {1'b0, ar_x} - {1'b0, ar_y} - {{W{1'b0}}, ar_cin};
        end else begin
            ar_wide = {1'b0, ar_x} + {1'b0, ar_y} + {{W{1'b0}}, ar_cin};
        end
        ar_res = ar_wide[W-1:0];
        ar_c   = ar_wide[W];
        if (ar_sub) begin
            ar_v = (ar_x[W-1] != ar_y[W-1]) && (ar_res[W-1] != ar_x[W-1]);
        end else begin
            ar_v = (ar_x[W-1] == ar_y[W-1]) && (ar_res[W-1] != ar_x[W-1]);
        end
    end

    // Final result and next flag value; CMP keeps A on the bus but flags the difference
    always_comb begin
        ans_res  = res_pre;
        flag_nxt = flag_ex;
        case (cls)
            FL_ARITH: begin
                if (op_dec != OP_CMP) begin
                    ans_res = ar_res;
                end
                flag_nxt = {ar_v, ar_res[W-1], (ar_res == '0), ar_c};
            end
            FL_LOGIC: flag_nxt = {1'b0, res_pre[W-1], (res_pre == '0), c_cur};
            FL_SHIFT: flag_nxt = {1'b0, res_pre[W-1], (res_pre == '0), sh_c};
            FL_CARRY: flag_nxt = {flag_ex[FW-1:1], c_set};
`ifdef ALU_MUL_EN
            FL_MUL:   flag_nxt = {mul_hi, res_pre[W-1], (res_pre == '0), mul_hi};
`endif
            default:  flag_nxt = flag_ex;
        endcase
    end

    assign ans_tmp = reset ? '0 : ans_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_ex       <= '0;
            data_out_buff <= '0;
        end else begin
            flag_ex <= flag_nxt;
            if (store_en) begin
                data_out_buff <= A;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vectors followed by randomized ops against an arithmetic reference model.
module tb_alu_exec;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] data_in;
    logic [4:0] op_dec;
    logic [7:0] ans_ex;
    logic [7:0] ans_tmp;
    logic [3:0] flag_ex;
    logic [7:0] data_out_buff;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] m_flags;
    logic [7:0] m_dob;
    logic [7:0] obs_ans;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk           (clk),
        .reset         (reset),
        .A             (A),
        .B             (B),
        .data_in       (data_in),
        .op_dec        (op_dec),
        .ans_ex        (ans_ex),
        .ans_tmp       (ans_tmp),
        .flag_ex       (flag_ex),
        .data_out_buff (data_out_buff)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Add/subtract on integers: carry = unsigned overflow / borrow, V = signed range exceeded
    function automatic void arith(input int x, input int y, input int cin, input bit sub,
                                  output int r, output logic [3:0] fl);
        int u;
        int s;
        bit c;
        bit v;
        if (sub) begin
            u = x - y - cin;
            s = sx(x) - sx(y) - cin;
            c = (u < 0);
        end else begin
            u = x + y + cin;
            s = sx(x) + sx(y) + cin;
            c = (u > 255);
        end
        r  = u & 255;
        v  = (s > 127) || (s < -128);
        fl = {v, r >= 128, r == 0, c};
    endfunction

    function automatic void ref_op(input logic [4:0] op, input int a, input int b, input int d,
                                   input int ax, input logic [3:0] f,
                                   output logic [7:0] res, output logic [3:0] fo, output bit st);
        int  r;
        int  c;
        int  co;
        int  p;
        bit  zn;
        c  = int'(f[0]);
        co = c;
        r  = a;
        fo = f;
        st = 1'b0;
        zn = 1'b0;
        p  = 0;
        case (op)
            5'd0:  arith(a, b, 0, 1'b0, r, fo);
            5'd1:  arith(a, b, c, 1'b0, r, fo);
            5'd2:  arith(a, b, 0, 1'b1, r, fo);
            5'd3:  arith(a, b, c, 1'b1, r, fo);
            5'd4:  begin r = a & b; zn = 1'b1; end
            5'd5:  begin r = a | b; zn = 1'b1; end
            5'd6:  begin r = a ^ b; zn = 1'b1; end
            5'd7:  begin r = 255 - a; zn = 1'b1; end
            5'd8:  arith(a, 1, 0, 1'b0, r, fo);
            5'd9:  arith(a, 1, 0, 1'b1, r, fo);
            5'd10: arith(0, a, 0, 1'b1, r, fo);
            5'd11: begin r = b; zn = 1'b1; end
            5'd12: begin r = (a * 2) % 256; co = a / 128; zn = 1'b1; end
            5'd13: begin r = a / 2; co = a % 2; zn = 1'b1; end
            5'd14: begin r = a / 2 + ((a >= 128) ? 128 : 0); co = a % 2; zn = 1'b1; end
            5'd15: begin r = (a * 2) % 256 + a / 128; co = a / 128; zn = 1'b1; end
            5'd16: begin r = a / 2 + (a % 2) * 128; co = a % 2; zn = 1'b1; end
            5'd17: begin r = (a * 2) % 256 + c; co = a / 128; zn = 1'b1; end
            5'd18: begin r = a / 2 + c * 128; co = a % 2; zn = 1'b1; end
            5'd19: begin arith(a, b, 0, 1'b1, r, fo); r = a; end
            5'd20: begin r = 255 - (a | b); zn = 1'b1; end
            5'd21: begin r = 255 - (a ^ b); zn = 1'b1; end
            5'd22: begin r = a; zn = 1'b1; end
            5'd23: begin r = ax; zn = 1'b1; end
            5'd24: begin r = d; zn = 1'b1; end
            5'd25: begin r = a; st = 1'b1; end
`ifdef ALU_MUL_EN
            5'd26: begin p = a * b; r = p % 256; fo = {p > 255, r >= 128, r == 0, p > 255}; end
`else
            5'd26: r = a;
`endif
            5'd27: begin r = (a % 16) * 16 + a / 16; zn = 1'b1; end
            5'd28: fo[0] = 1'b0;
            5'd29: fo[0] = 1'b1;
            5'd30: arith(ax, a, 0, 1'b0, r, fo);
            default: r = ax;
        endcase
        if (zn) fo = {1'b0, r >= 128, r == 0, co[0]};
        res = 8'(r);
    endfunction

    // One op: check the combinational result before the edge, flags/store buffer after it
    task automatic step(input logic rst, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic [7:0] ax, input string tag);
        logic [7:0] e_ans;
        logic [3:0] e_fl;
        bit         e_st;
        @(negedge clk);
        reset   = rst;
        op_dec  = op;
        A       = a;
        B       = b;
        data_in = d;
        ans_ex  = ax;
        ref_op(op, int'(a), int'(b), int'(d), int'(ax), m_flags, e_ans, e_fl, e_st);
        if (rst) begin
            e_ans = 8'h00;
            e_fl  = 4'h0;
        end
        #1;
        obs_ans = ans_tmp;
        chk({tag, "_ans"}, ans_tmp, e_ans);
        @(posedge clk);
        #1;
        m_flags = e_fl;
        if (rst) m_dob = 8'h00;
        else if (e_st) m_dob = a;
        chk({tag, "_flags"}, {4'h0, flag_ex}, {4'h0, m_flags});
        chk({tag, "_dob"}, data_out_buff, m_dob);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        reset   = 1'b1;
        op_dec  = 5'b11111;
        A       = 8'h00;
        B       = 8'h00;
        data_in = 8'h00;
        ans_ex  = 8'h00;
        m_flags = 4'h0;
        m_dob   = 8'h00;

        step(1'b1, 5'b11001, 8'hAA, 8'h00, 8'h00, 8'h00, "rst_store");
        chk("rst_ans_zero", obs_ans, 8'h00);

        step(1'b0, 5'b00100, 8'd64, 8'd192, 8'h00, 8'h00, "and");
        chk("and_ans", obs_ans, 8'h40);
        chk("and_flags", {4'h0, flag_ex}, 8'h00);

        step(1'b0, 5'b00000, 8'd64, 8'd192, 8'h00, 8'h00, "add");
        chk("add_ans", obs_ans, 8'h00);
        chk("add_flags", {4'h0, flag_ex}, 8'h03);

        step(1'b0, 5'b00010, 8'd64, 8'd192, 8'h00, 8'h00, "sub");
        chk("sub_ans", obs_ans, 8'h80);
        chk("sub_flags", {4'h0, flag_ex}, 8'h0D);

        step(1'b0, 5'b11100, 8'h12, 8'h00, 8'h00, 8'h00, "clc");
        chk("clc_flags", {4'h0, flag_ex}, 8'h0C);
        step(1'b0, 5'b11101, 8'h12, 8'h00, 8'h00, 8'h00, "stc");
        chk("stc_flags", {4'h0, flag_ex}, 8'h0D);

        step(1'b0, 5'b00001, 8'd64, 8'd192, 8'h00, 8'h00, "adc");
        chk("adc_ans", obs_ans, 8'h01);

        step(1'b0, 5'b11001, 8'd192, 8'd1, 8'h00, 8'h00, "store");
        chk("store_dob", data_out_buff, 8'hC0);
        chk("store_flags", {4'h0, flag_ex}, 8'h01);

        step(1'b0, 5'b11011, 8'd192, 8'd1, 8'h00, 8'h00, "swap");
        chk("swap_ans", obs_ans, 8'h0C);

        step(1'b0, 5'b11010, 8'd192, 8'd1, 8'h00, 8'h00, "mul");
        chk("mul_ans", obs_ans, 8'hC0);
`ifdef ALU_MUL_EN
        chk("mul_flags", {4'h0, flag_ex}, 8'h04);
`else
        chk("mul_flags", {4'h0, flag_ex}, 8'h01);
`endif

        step(1'b1, 5'b11001, 8'h55, 8'h00, 8'h00, 8'h00, "rst_mid_store");
        chk("rst_mid_ans", obs_ans, 8'h00);
        chk("rst_mid_dob", data_out_buff, 8'h00);
        chk("rst_mid_flags", {4'h0, flag_ex}, 8'h00);

        step(1'b0, 5'b00001, 8'd1, 8'd2, 8'h00, 8'h00, "adc_after_rst");
        chk("adc_after_rst_ans", obs_ans, 8'h03);

        step(1'b0, 5'b00000, 8'hFF, 8'h01, 8'h00, 8'h00, "add_wrap");
        chk("add_wrap_flags", {4'h0, flag_ex}, 8'h03);

        for (int i = 0; i < 600; i++) begin
            logic       r_rst;
            logic [4:0] r_op;
            r_rst = ($urandom_range(0, 19) == 0);
            r_op  = 5'($urandom_range(0, 31));
            step(r_rst, r_op, pick(), pick(), 8'($urandom), pick(), $sformatf("rnd%0d_op%0d", i, r_op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
